// File: rtl/reset_sync.sv
// Reset conditioning stage: a raw active-low reset is applied on the clock edge and
// released through an N_STAGES flop chain, so a whole clock domain leaves reset on one edge.
module reset_sync #(
    parameter int N_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_RST
);

    generate
        if (N_STAGES < 1) begin : g_bad_n_stages
            $error("reset_sync: N_STAGES must be >= 1");
        end
    endgenerate

    logic [N_STAGES-1:0] sync_q;
    logic [N_STAGES-1:0] sync_d;

    // Release path: a one enters at the head and walks toward the output flop.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = 1'b1;
        for (int i = 1; i < N_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // No power-up value: the chain is only defined after RST is sampled low.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign SYNC_RST = sync_q[N_STAGES-1];

endmodule

// File: tb/tb_reset_sync.sv
// Bench for reset_sync: four instances (N_STAGES 1..4) share one clock and raw reset;
// a consecutive-ones reference model feeds a per-edge expectation queue checked by a monitor.
module tb_reset_sync;

    localparam int NUM_INST = 4;

    typedef struct {
        bit       known;
        bit [3:0] exp_sync;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [NUM_INST-1:0] sync_rst;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatch = 0;
    int   ones_run   = 0;
    bit   model_known = 1'b0;
    bit   started    = 1'b0;
    bit   done       = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NUM_INST; gi++) begin : g_dut
            reset_sync #(.N_STAGES(gi + 1)) u_dut (
                .CLK      (clk),
                .RST      (rst),
                .SYNC_RST (sync_rst[gi])
            );
        end
    endgenerate

    // Reference: SYNC_RST is high once at least N edges in a row have sampled RST high.
    task automatic model_edge(input bit v);
        exp_t e;
        if (!v) begin
            ones_run    = 0;
            model_known = 1'b1;
        end else if (ones_run < 1000) begin
            ones_run++;
        end
        e.known = model_known;
        for (int k = 0; k < NUM_INST; k++) begin
            e.exp_sync[k] = (ones_run >= k + 1);
        end
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    // Drive mid-cycle; a glitch is a 2 ns low pulse that ends well before the next edge.
    task automatic drive_cycle(input bit v, input bit glitch);
        @(negedge clk);
        rst = v;
        if (glitch && v) begin
            rst = 1'b0;
            #2;
            rst = 1'b1;
        end
        model_edge(v);
    endtask

    task automatic drive_n(input bit v, input int n);
        for (int i = 0; i < n; i++) drive_cycle(v, 1'b0);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (started && !done) begin
                    n_compared++;
                    n_mismatch++;
                    $display("FAIL missing_expectation t=%0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                if (e.known) begin
                    for (int k = 0; k < NUM_INST; k++) begin
                        n_compared++;
                        if (sync_rst[k] !== e.exp_sync[k]) begin
                            n_mismatch++;
                            $display("FAIL sync_rst_n%0d t=%0t actual=%b required=%b",
                                     k + 1, $time, sync_rst[k], e.exp_sync[k]);
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit v;
        rst = 1'b1;
        // Scenario 1: RST=0 at t=10, RST=1 at t=30.
        drive_n(1'b0, 2);
        drive_n(1'b1, 6);
        // Reassert in steady state for exactly one edge.
        drive_n(1'b0, 1);
        drive_n(1'b1, 6);
        // Mid-release reset: only two high edges, then low again.
        drive_n(1'b0, 3);
        drive_n(1'b1, 2);
        drive_n(1'b0, 1);
        drive_n(1'b1, 6);
        // Glitches between edges have no effect.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1);
        drive_n(1'b0, 1);
        drive_n(1'b1, 6);
        // Long reset.
        drive_n(1'b0, 100);
        drive_n(1'b1, 6);
        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 5) != 0);
            drive_cycle(v, v && ($urandom_range(0, 3) == 0));
        end
        drive_n(1'b1, 6);
        // Let the monitor consume the last expectation.
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL unconsumed_expectations left=%0d required=0", exp_q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        n_compared++;
        n_mismatch++;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
